// File: rtl/mem_dump_reader.sv
// BRAM readback engine: reads a run of 32-bit words over the debug port
// and streams them LSB-first on a valid/ready byte interface.
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    last_byte;

  assign accept    = valid_q && tx_ready;
  assign last_byte = (byte_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d      = {base_addr[ADDR_WIDTH-1:2], 2'b00};
            remaining_d = word_count;
            busy_d      = 1'b1;
            state_d     = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        shift_d     = mem_data;
        valid_d     = 1'b1;
        byte_idx_d  = 2'd0;
        remaining_d = remaining_q - ADDR_WIDTH'(1);
        state_d     = SEND;
      end
      SEND: begin
        // Wrap of the address is the natural modulo of the adder.
        unique case (1'b1)
          accept && !last_byte: begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
          accept && last_byte && (remaining_q != '0): begin
            valid_d = 1'b0;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            state_d = RD;
          end
          accept && last_byte && (remaining_q == '0): begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign tx_data  = shift_q[{byte_idx_q, 3'b000} +: 8];
  assign tx_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a 1-cycle-latency BRAM model
// and a byte/done/busy monitor.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  word_count;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  logic [7:0]  rxq [$];
  logic [7:0]  expq [$];
  int          done_cnt;
  int          busy_cyc;
  int          total = 0;
  int          bad = 0;
  int          e;

  mem_dump_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (tx_valid && tx_ready) rxq.push_back(tx_data);
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(int n);
    while (e < n) tick();
  endtask

  task automatic do_start(logic [9:0] b, logic [9:0] n);
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    @(posedge clk);
    #1;
    e     = 0;
    start = 1'b0;
  endtask

  task automatic clear_mon();
    rxq.delete();
    done_cnt = 0;
    busy_cyc = 0;
  endtask

  task automatic chk_bytes(string tag);
    chk({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]   = 32'h11223344;
    mem[1]   = 32'hAABBCCDD;
    mem[2]   = 32'h00000014;
    mem[3]   = 32'h01020304;
    mem[255] = 32'hCAFEBABE;
    rst        = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    tx_ready   = 1'b1;
    e          = 0;
    clear_mon();

    // reset state
    repeat (3) tick();
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", tx_data, 0);
    rst = 1'b1;
    tick();

    // basic dump
    clear_mon();
    do_start(10'h000, 10'd3);
    chk("b_addr0", mem_addr, 10'h000);
    chk("b_busy0", busy, 1);
    chk("b_valid0", tx_valid, 0);
    run_to(2);
    chk("b_valid2", tx_valid, 1);
    chk("b_data2", tx_data, 8'h44);
    run_to(6);
    chk("b_addr1", mem_addr, 10'h004);
    run_to(12);
    chk("b_addr2", mem_addr, 10'h008);
    run_to(17);
    chk("b_done17", done, 0);
    run_to(18);
    chk("b_done18", done, 1);
    chk("b_busy18", busy, 0);
    tick();
    chk("b_done19", done, 0);
    chk("b_busycyc", busy_cyc, 18);
    chk("b_donecnt", done_cnt, 1);
    expq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC,
             8'hBB, 8'hAA, 8'h14, 8'h00, 8'h00, 8'h00};
    chk_bytes("basic");

    // backpressure on byte 0x22
    clear_mon();
    do_start(10'h000, 10'd3);
    run_to(4);
    chk("bp_pre", tx_data, 8'h22);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_data%0d", i), tx_data, 8'h22);
      chk($sformatf("bp_valid%0d", i), tx_valid, 1);
    end
    tx_ready = 1'b1;
    run_to(22);
    chk("bp_done22", done, 0);
    run_to(23);
    chk("bp_done23", done, 1);
    tick();
    chk("bp_busycyc", busy_cyc, 23);
    chk("bp_donecnt", done_cnt, 1);
    chk_bytes("bp");

    // wrap and alignment
    clear_mon();
    do_start(10'h3FE, 10'd2);
    chk("w_addr0", mem_addr, 10'h3FC);
    run_to(6);
    chk("w_addr1", mem_addr, 10'h000);
    run_to(12);
    chk("w_done", done, 1);
    tick();
    expq = '{8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h44, 8'h33, 8'h22, 8'h11};
    chk_bytes("wrap");

    // zero count
    clear_mon();
    do_start(10'h000, 10'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_valid", tx_valid, 0);
    tick();
    chk("z_done1", done, 0);
    tick();
    chk("z_busycyc", busy_cyc, 0);
    chk("z_bytes", rxq.size(), 0);
    chk("z_donecnt", done_cnt, 1);

    // start ignored while busy
    clear_mon();
    do_start(10'h008, 10'd2);
    run_to(3);
    start      = 1'b1;
    base_addr  = 10'h000;
    word_count = 10'd3;
    tick();
    start = 1'b0;
    run_to(6);
    chk("i_addr1", mem_addr, 10'h00C);
    run_to(12);
    chk("i_done", done, 1);
    repeat (3) tick();
    chk("i_donecnt", done_cnt, 1);
    chk("i_busy", busy, 0);
    expq = '{8'h14, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    chk_bytes("ign");

    // back-to-back: start on the done cycle
    clear_mon();
    do_start(10'h000, 10'd1);
    run_to(6);
    chk("bb_done1", done, 1);
    do_start(10'h004, 10'd1);
    chk("bb_addr", mem_addr, 10'h004);
    chk("bb_busy", busy, 1);
    run_to(2);
    chk("bb_data", tx_data, 8'hDD);
    run_to(6);
    chk("bb_done2", done, 1);
    tick();
    chk("bb_donecnt", done_cnt, 2);
    expq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk_bytes("b2b");

    // reset mid-dump
    clear_mon();
    do_start(10'h000, 10'd4);
    run_to(3);
    rst = 1'b0;
    #1;
    chk("r_valid", tx_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_done", done, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("r_donecnt", done_cnt, 0);
    chk("r_bytes", rxq.size(), 1);
    clear_mon();
    do_start(10'h004, 10'd1);
    chk("r2_addr", mem_addr, 10'h004);
    run_to(2);
    chk("r2_valid", tx_valid, 1);
    chk("r2_data", tx_data, 8'hDD);
    run_to(6);
    chk("r2_done", done, 1);
    tick();
    expq = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk_bytes("rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
